// File: rtl/i281_imem_pkg.sv
// Shared definitions for the i281 field-loadable instruction memory:
// loader FSM states, byte width, reset word and the flat-bus slice helper.
// Optional build macro used by the loader: IMEM_CHECKSUM_EN.
package i281_imem_pkg;

    // Width of one program byte on the serial load port.
    localparam int BYTE_W = 8;

    // Word value every location holds after reset (an i281 NOP).
    localparam int NOP_WORD = 0;

    // Loader FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } state_t;

    // LSB position of word idx on the flat instruction bus.
    function automatic int flat_lsb(input int idx, input int data_w);
        return idx * data_w;
    endfunction

endpackage

// File: rtl/i281_imem_word_assembler.sv
// Byte-to-word assembler for the instruction loader. Shifts program bytes
// in MSB-first and flags the byte that completes a word. The loader holds
// it in clear whenever it is not receiving, so each word starts at byte 0.
module i281_imem_word_assembler
    import i281_imem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_ready,
    output logic [DATA_W-1:0] word
);

    // Bytes per word, and a counter width that stays legal for BPW==1.
    localparam int BPW   = DATA_W / BYTE_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [IDX_W-1:0] byte_idx;

    // The byte being accepted right now is the last one of the word.
    assign word_ready = shift_en && (byte_idx == IDX_W'(BPW - 1));

    // Shift register and byte counter; the cast drops the oldest byte so
    // the same expression also covers single-byte words.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking (<=) so every flop samples
        // pre-edge values; blocking here would create order-dependent races.
        if (!rst_n) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (clear) begin
            byte_idx <= '0;
            word     <= '0;
        end else if (shift_en) begin
            word     <= DATA_W'({word, byte_in});
            byte_idx <= byte_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/i281_imem_loader.sv
// Field-loadable instruction memory for the i281 CPU. Holds DEPTH words of
// DATA_W bits, accepts a new program over a byte-serial valid/ready port,
// exposes every word on a flat bus for the parallel instruction-select
// datapath, and offers a registered debug read port.
// Build option: define IMEM_CHECKSUM_EN to get a 16-bit running sum of the
// words written by the current load; otherwise checksum is tied to 0.
module i281_imem_loader
    import i281_imem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_start,
    input  logic [ADDR_W-1:0]       load_base,
    input  logic [ADDR_W:0]         load_count,
    input  logic                    byte_valid,
    input  logic [BYTE_W-1:0]       byte_data,
    output logic                    byte_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic [DEPTH*DATA_W-1:0] imem_flat,
    output logic [15:0]             checksum
);

    state_t              state;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W:0]     remaining;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                shift_en;
    logic                asm_clear;
    logic                word_ready;
    logic [DATA_W-1:0]   asm_word;
    logic                wr_en;
    logic                count_bad;
    logic [ADDR_W-1:0]   next_addr;

    // A byte transfers only while receiving and the handshake completes.
    assign shift_en  = (state == RECV) && byte_valid && byte_ready;
    // Outside RECV the assembler is held empty, so every word starts fresh.
    assign asm_clear = (state != RECV);
    // The WRITE state commits exactly one assembled word.
    assign wr_en     = (state == WRITE);

    // A zero-length or oversize load is rejected without touching memory.
    assign count_bad = (load_count == '0) || (load_count > (ADDR_W+1)'(DEPTH));

    // Write address advances modulo DEPTH; wrapping past the top is legal.
    assign next_addr = (wr_addr == ADDR_W'(DEPTH - 1)) ? '0 : wr_addr + ADDR_W'(1);

    i281_imem_word_assembler #(
        .DATA_W (DATA_W)
    ) u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (asm_clear),
        .shift_en   (shift_en),
        .byte_in    (byte_data),
        .word_ready (word_ready),
        .word       (asm_word)
    );

    // Loader FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_addr    <= '0;
            remaining  <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    if (load_start) begin
                        wr_addr   <= load_base;
                        remaining <= load_count;
                        busy      <= 1'b1;
                        if (count_bad) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            err        <= 1'b0;
                            byte_ready <= 1'b1;
                            state      <= RECV;
                        end
                    end
                end

                RECV: begin
                    // Stalls here for as long as byte_valid stays low.
                    if (word_ready) begin
                        byte_ready <= 1'b0;
                        state      <= WRITE;
                    end
                end

                WRITE: begin
                    wr_addr   <= next_addr;
                    remaining <= remaining - (ADDR_W+1)'(1);
                    if (remaining == (ADDR_W+1)'(1)) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        byte_ready <= 1'b1;
                        state      <= RECV;
                    end
                end

                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // Instruction storage: cleared on reset, one word written per WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this array is reset on purpose -- an aborted load must leave
        // no partial program behind, so it maps to flops rather than RAM.
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(NOP_WORD);
            end
        end else if (wr_en) begin
            mem[wr_addr] <= asm_word;
        end
    end

    // Debug read port: one-cycle latency, returns the pre-write word when
    // the same address is being written on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    // Flatten the array for the parallel instruction-select datapath.
    always_comb begin
        // NOTE: assign a default before the loop so every bit is written on
        // every pass; a missed bit in always_comb would infer a latch.
        imem_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            imem_flat[flat_lsb(i, DATA_W) +: DATA_W] = mem[i];
        end
    end

`ifdef IMEM_CHECKSUM_EN
    // Running modulo-2^16 sum of the low 16 bits of each word written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= 16'd0;
        end else if ((state == IDLE) && load_start) begin
            checksum <= 16'd0;
        end else if (wr_en) begin
            checksum <= checksum + 16'(asm_word);
        end
    end
`else
    // Feature disabled: constant output, no adder.
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_i281_imem_loader.sv
// Directed self-checking bench for i281_imem_loader (DATA_W=16, DEPTH=16).
// Expected memory contents are kept in a local flat-bus model.
module tb_i281_imem_loader;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int FLAT_W = DEPTH * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start;
    logic [ADDR_W-1:0] load_base;
    logic [ADDR_W:0]   load_count;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [FLAT_W-1:0] imem_flat;
    logic [15:0]       checksum;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    logic [FLAT_W-1:0] exp_flat;

    i281_imem_loader #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_base  (load_base),
        .load_count (load_count),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .imem_flat  (imem_flat),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [FLAT_W-1:0] obs,
                         input logic [FLAT_W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse load_start for one cycle; returns on the negedge after it was sampled.
    task automatic start_load(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] count);
        @(negedge clk);
        load_base  = base;
        load_count = count;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("byte_ready_wait", byte_ready, 1);
        @(negedge clk);
    endtask

    // Wait (bounded) for done, then confirm it lasts exactly one cycle.
    task automatic wait_done();
        int n;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        load_base  = '0;
        load_count = '0;
        byte_valid = 1'b0;
        byte_data  = '0;
        rd_addr    = '0;
        exp_flat   = '0;

        // Power-on reset state.
        #1;
        check("rst_busy",       busy, 0);
        check("rst_byte_ready", byte_ready, 0);
        check("rst_done",       done, 0);
        check("rst_err",        err, 0);
        check("rst_flat",       imem_flat, exp_flat);
        check("rst_rd_data",    rd_data, 0);
        check("rst_checksum",   checksum, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic load: two words at address 0, bytes back-to-back.
        start_load(4'd0, 5'd2);
        check("basic_busy", busy, 1);
        check("basic_ready", byte_ready, 1);
        send_byte(8'h3C);
        send_byte(8'h02);
        send_byte(8'hAC);
        send_byte(8'h0E);
        byte_valid = 1'b0;
        exp_flat[0*16 +: 16] = 16'h3C02;
        check("basic_word0_early", imem_flat, exp_flat);
        check("basic_done_early", done, 0);
        @(negedge clk);
        exp_flat[1*16 +: 16] = 16'hAC0E;
        check("basic_done", done, 1);
        check("basic_busy_fin", busy, 1);
        check("basic_flat", imem_flat, exp_flat);
`ifdef IMEM_CHECKSUM_EN
        check("basic_checksum", checksum, 16'hE810);
`else
        check("basic_checksum", checksum, 16'h0000);
`endif
        @(negedge clk);
        check("basic_done_drop", done, 0);
        check("basic_busy_drop", busy, 0);
        check("basic_err", err, 0);
        rd_addr = 4'd1;
        @(negedge clk);
        check("rd_addr1", rd_data, 16'hAC0E);
        rd_addr = 4'd0;
        @(negedge clk);
        check("rd_addr0", rd_data, 16'h3C02);

        // Wrap: load at 15 spills into address 0.
        start_load(4'd15, 5'd2);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h78);
        byte_valid = 1'b0;
        wait_done();
        exp_flat[15*16 +: 16] = 16'h1234;
        exp_flat[0*16 +: 16]  = 16'h5678;
        check("wrap_flat", imem_flat, exp_flat);
        check("wrap_err", err, 0);
`ifdef IMEM_CHECKSUM_EN
        check("wrap_checksum", checksum, 16'h68AC);
`else
        check("wrap_checksum", checksum, 16'h0000);
`endif

        // Illegal counts: rejected immediately with a done pulse.
        start_load(4'd3, 5'd0);
        check("cnt0_done", done, 1);
        check("cnt0_err", err, 1);
        check("cnt0_ready", byte_ready, 0);
        @(negedge clk);
        check("cnt0_done_drop", done, 0);
        check("cnt0_err_sticky", err, 1);
        check("cnt0_ready_idle", byte_ready, 0);
        check("cnt0_flat", imem_flat, exp_flat);
        check("cnt0_checksum", checksum, 0);

        start_load(4'd3, 5'd17);
        check("cnt17_done", done, 1);
        check("cnt17_err", err, 1);
        check("cnt17_ready", byte_ready, 0);
        @(negedge clk);
        check("cnt17_done_drop", done, 0);
        check("cnt17_err_sticky", err, 1);
        check("cnt17_flat", imem_flat, exp_flat);

        // Stalled byte stream, with a stray load_start while busy.
        start_load(4'd4, 5'd1);
        check("stall_err_cleared", err, 0);
        send_byte(8'hBE);
        byte_valid = 1'b0;
        load_base  = 4'd9;
        load_count = 5'd1;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        @(negedge clk);
        check("stall_still_busy", busy, 1);
        send_byte(8'hEF);
        byte_valid = 1'b0;
        wait_done();
        exp_flat[4*16 +: 16] = 16'hBEEF;
        check("stall_flat", imem_flat, exp_flat);
        @(negedge clk);
        check("stray_start_ignored", busy, 0);

        // Abort: reset mid-cycle after 3 bytes of a 2-word load.
        start_load(4'd8, 5'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        byte_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        exp_flat = '0;
        check("abort_flat", imem_flat, exp_flat);
        check("abort_busy", busy, 0);
        check("abort_ready", byte_ready, 0);
        check("abort_rd_data", rd_data, 0);
        check("abort_checksum", checksum, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal load after the abort.
        start_load(4'd2, 5'd1);
        send_byte(8'hCA);
        send_byte(8'hFE);
        byte_valid = 1'b0;
        wait_done();
        exp_flat[2*16 +: 16] = 16'hCAFE;
        check("post_abort_flat", imem_flat, exp_flat);
`ifdef IMEM_CHECKSUM_EN
        check("post_abort_checksum", checksum, 16'hCAFE);
`else
        check("post_abort_checksum", checksum, 16'h0000);
`endif
        rd_addr = 4'd2;
        @(negedge clk);
        check("post_abort_rd", rd_data, 16'hCAFE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
